gp10_arbiter: RTL and testbench

Two-requester bus arbiter and access sequencer for the GP10 I/O peripheral (LEDR/7-segment write register, switch read register). It accepts word read/write requests from the processor core and a secondary master (debug/monitor unit), grants them round-robin, and drives the peripheral's memw/read_en/dataw strobes for exactly one cycle per transaction. Read data is captured from datar and returned with a one-cycle ack. The block sits between the masters and the GP10 peripheral, which it fully owns.

---
 rtl/gp10_bus_pkg.sv | 16 +
 rtl/gp10_rr_pick.sv | 28 ++
 rtl/gp10_arbiter.sv | 99 +++++++++
 tb/tb_gp10_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp10_bus_pkg.sv
// rtl/gp10_bus_pkg.sv - shared types and defaults for the GP10 bus arbiter
package gp10_bus_pkg;

  localparam int GP10_N_MASTERS = 2;
  localparam int GP10_DW        = 16;
  localparam int GP10_ID_W      = (GP10_N_MASTERS > 1) ? $clog2(GP10_N_MASTERS) : 1;

  typedef logic [GP10_ID_W-1:0] mid_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/gp10_rr_pick.sv
// rtl/gp10_rr_pick.sv - combinational round-robin picker
// Search starts at the requester after last_grant and wraps around.
module gp10_rr_pick #(
  parameter int N_MASTERS = 2,
  parameter int ID_W      = 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  output logic                 valid,
  output logic [ID_W-1:0]      winner
);

  int idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      idx = (int'(last_grant) + off) % N_MASTERS;
      if (!valid && req[idx[ID_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gp10_arbiter.sv
// rtl/gp10_arbiter.sv - two-master round-robin arbiter and GP10 access sequencer
// Each transaction is IDLE -> ACCESS (one strobe cycle) -> RESP (one ack cycle).
module gp10_arbiter
  import gp10_bus_pkg::*;
#(
  parameter int N_MASTERS = GP10_N_MASTERS,
  parameter int DW        = GP10_DW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    req,
  input  logic [N_MASTERS-1:0]    we,
  input  logic [N_MASTERS*DW-1:0] wdata,
  output logic [N_MASTERS-1:0]    ack,
  output logic [DW-1:0]           rdata,
  output logic                    memw,
  output logic                    read_en,
  output logic [DW-1:0]           dataw,
  input  logic [DW-1:0]           datar
);

  localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  state_t          state, state_nxt;
  logic [ID_W-1:0] id_q;
  logic            we_q;
  logic [ID_W-1:0] last_grant;
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [DW-1:0]   wdata_sel;

  gp10_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (ID_W'(i) == pick_id) wdata_sel = wdata[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and ack are registered one state ahead so they line up with ACCESS/RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q       <= '0;
      we_q       <= 1'b0;
      dataw      <= '0;
      last_grant <= ID_W'(N_MASTERS - 1);
      ack        <= '0;
      rdata      <= '0;
      memw       <= 1'b0;
      read_en    <= 1'b0;
    end else begin
      memw    <= 1'b0;
      read_en <= 1'b0;
      ack     <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            id_q    <= pick_id;
            we_q    <= we[pick_id];
            dataw   <= wdata_sel;
            memw    <= we[pick_id];
            read_en <= !we[pick_id];
          end
        end
        ACCESS: begin
          if (!we_q) rdata <= datar;
          ack <= N_MASTERS'(1) << id_q;
        end
        RESP: last_grant <= id_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gp10_arbiter.sv
// tb/tb_gp10_arbiter.sv - scoreboard bench for gp10_arbiter
module tb_gp10_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            memw;
  logic            read_en;
  logic [DW-1:0]   dataw;
  logic [DW-1:0]   datar = '0;

  gp10_arbiter #(.N_MASTERS(N), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata),
    .memw    (memw),
    .read_en (read_en),
    .dataw   (dataw),
    .datar   (datar)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          is_write;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   gap_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push(input int id, input bit w, input logic [15:0] d);
    exp_t e;
    e.id = id; e.is_write = w; e.data = d;
    exp_q.push_back(e);
  endtask

  // Strobe must match queue head; ack must follow exactly one cycle later.
  task automatic monitor();
    bit   strobe_prev = 0;
    int   cyc = 0;
    int   last_st = -1;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_mode) last_st = -1;
      if (reset) begin
        strobe_prev = 0;
        continue;
      end
      if (strobe_prev) begin
        strobe_prev = 0;
        if (exp_q.size() == 0) fail_msg("ack_without_expectation");
        else begin
          e = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1 << e.id));
          if (!e.is_write) chk("rdata", 32'(rdata), 32'(e.data));
        end
      end else if (ack != '0) begin
        chk("unexpected_ack", 32'(ack), 32'(0));
      end
      if (memw || read_en) begin
        chk("strobe_exclusive", 32'(memw & read_en), 32'(0));
        if (exp_q.size() == 0) fail_msg("unexpected_strobe");
        else begin
          e = exp_q[0];
          chk("memw_dir", 32'(memw), 32'(e.is_write));
          chk("read_en_dir", 32'(read_en), 32'(!e.is_write));
          if (e.is_write) chk("dataw", 32'(dataw), 32'(e.data));
        end
        if (gap_mode && last_st >= 0) chk("strobe_gap", 32'(cyc - last_st), 32'(3));
        last_st = cyc;
        strobe_prev = 1;
      end
    end
  endtask

  task automatic wait_ack(input int id);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[id]) return;
    end
    fail_msg($sformatf("timeout_ack%0d", id));
  endtask

  task automatic wait_strobe();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (memw || read_en) return;
    end
    fail_msg("timeout_strobe");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic stimulus();
    // reset state
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_memw", 32'(memw), 0);
    chk("rst_read_en", 32'(read_en), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_dataw", 32'(dataw), 0);
    reset = 1'b0;
    @(negedge clk);

    // single write from master 0
    we[0] = 1'b1; wdata[0*DW +: DW] = 16'h1234; req[0] = 1'b1;
    push(0, 1, 16'h1234);
    wait_ack(0);
    req[0] = 1'b0;
    @(negedge clk);

    // single read from master 1, then a write must leave rdata alone
    datar = 16'hA5A5;
    we[1] = 1'b0; req[1] = 1'b1;
    push(1, 0, 16'hA5A5);
    wait_ack(1);
    req[1] = 1'b0;
    datar = 16'h0000;
    @(negedge clk);
    wdata[0*DW +: DW] = 16'h5555; req[0] = 1'b1;
    push(0, 1, 16'h5555);
    wait_ack(0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("rdata_hold_after_write", 32'(rdata), 32'h0000_A5A5);

    // contention from reset: 0,1,0,1
    do_reset();
    we = 2'b11;
    wdata[0*DW +: DW] = 16'h0001;
    wdata[1*DW +: DW] = 16'h0002;
    push(0, 1, 16'h0001); push(1, 1, 16'h0002);
    push(0, 1, 16'h0001); push(1, 1, 16'h0002);
    gap_mode = 1;
    req = 2'b11;
    wait_ack(0); wait_ack(1); wait_ack(0); wait_ack(1);
    req = 2'b00;
    gap_mode = 0;
    @(negedge clk);

    // fairness: m1 alone wins, then a tie goes to m0
    we = 2'b00;
    datar = 16'h1111;
    req[1] = 1'b1;
    push(1, 0, 16'h1111);
    wait_ack(1);
    req[1] = 1'b0;
    @(negedge clk);
    datar = 16'h2222;
    req = 2'b11;
    push(0, 0, 16'h2222); push(1, 0, 16'h2222);
    wait_ack(0);
    req[0] = 1'b0;
    wait_ack(1);
    req[1] = 1'b0;
    @(negedge clk);

    // early drop: m0 pulses req only during m1's ACCESS
    datar = 16'h3333;
    req[1] = 1'b1;
    push(1, 0, 16'h3333);
    wait_strobe();
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    req[1] = 1'b0;
    chk("early_drop_ack1", 32'(ack), 32'h2);
    repeat (4) @(negedge clk);

    // drop right after latch: transaction still completes
    we[0] = 1'b1; wdata[0*DW +: DW] = 16'h0BAD; req[0] = 1'b1;
    push(0, 1, 16'h0BAD);
    wait_strobe();
    req[0] = 1'b0;
    @(negedge clk);
    chk("late_drop_ack0", 32'(ack), 32'h1);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    // reset during ACCESS
    wdata[0*DW +: DW] = 16'h7777; req[0] = 1'b1;
    push(0, 1, 16'h7777);
    wait_strobe();
    reset = 1'b1;
    #1;
    chk("abort_memw", 32'(memw), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_rdata", 32'(rdata), 0);
    chk("abort_dataw", 32'(dataw), 0);
    exp_q.delete();
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_ack_after_abort", 32'(ack), 0);
    end

    // arbiter usable again from IDLE after the abort
    datar = 16'h3C3C;
    we[1] = 1'b0; req[1] = 1'b1;
    push(1, 0, 16'h3C3C);
    wait_ack(1);
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #100000;
        fail_msg("global_timeout");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
